fu_issue_arbiter: RTL and testbench

//   Shares one functional unit between NUM_REQ issue stations. Each cycle it picks one ready station by

---
 rtl/fu_issue_arbiter.sv | 123 ++++++++++++
 tb/tb_fu_issue_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fu_issue_arbiter.sv
// fu_issue_arbiter: round-robin issue of NUM_REQ stations into a one-entry FU stage with II, kill and spec remap.
// Optional ISSUE_ARB_PERF_EN adds saturating per-station grant and stall counters.
module fu_issue_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int INST_ID_BIT = 8,
  parameter int NUM_REG = 8,
  parameter int IMM_BIT = 4,
  parameter int SPEC_DEPTH = 4,
  parameter int FU_II = 1,
  localparam int REG_ID_BIT = $clog2(NUM_REG),
  localparam int SPEC_LEVEL_BIT = $clog2(SPEC_DEPTH) + 1,
  localparam int INFO_BIT = INST_ID_BIT + 3 * REG_ID_BIT + IMM_BIT,
  localparam int PTR_BIT = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_REQ-1:0]                       req_vld_i,
  output logic [NUM_REQ-1:0]                       req_rdy_o,
  input  logic [NUM_REQ*INFO_BIT-1:0]              req_info_i,
  input  logic [NUM_REQ*SPEC_LEVEL_BIT-1:0]        req_spec_level_i,
  output logic                                     out_vld_o,
  input  logic                                     out_rdy_i,
  output logic [INFO_BIT-1:0]                      out_info_o,
  output logic [SPEC_LEVEL_BIT-1:0]                out_spec_level_o,
  input  logic                                     br_pred_vld_i,
  output logic                                     br_pred_rdy_o,
  input  logic                                     br_pred_succ_i,
  input  logic [SPEC_LEVEL_BIT-1:0]                br_pred_fail_level_i,
  input  logic [SPEC_LEVEL_BIT*(SPEC_DEPTH+1)-1:0] br_pred_succ_nxt_levels_i,
`ifdef ISSUE_ARB_PERF_EN
  output logic [NUM_REQ*16-1:0]                    perf_grant_cnt_o,
  output logic [15:0]                              perf_stall_cnt_o,
`endif
  output logic                                     idle_o
);
  localparam logic [3:0] II_RELOAD = 4'(FU_II - 1);
  logic fail, succ, kill, hs, slot_free, found, grant;
  logic [NUM_REQ-1:0] elig;
  logic [PTR_BIT-1:0] rr_q, rr_d, gnt_idx;
  logic out_vld_q, out_vld_d;
  logic [INFO_BIT-1:0] info_q, info_d;
  logic [SPEC_LEVEL_BIT-1:0] lvl_q, lvl_d, lvl_remap;
  logic [3:0] ii_q, ii_d;
  int j;
  assign fail = br_pred_vld_i & ~br_pred_succ_i;
  assign succ = br_pred_vld_i & br_pred_succ_i;
  assign kill = fail & out_vld_q & (lvl_q >= br_pred_fail_level_i);
  assign out_vld_o = out_vld_q & ~kill & (ii_q == 4'd0);
  assign hs = out_vld_o & out_rdy_i;
  assign out_info_o = info_q;
  assign out_spec_level_o = (succ & out_vld_q) ? lvl_remap : lvl_q;
  assign br_pred_rdy_o = 1'b1;
  assign idle_o = ~out_vld_q & (ii_q == 4'd0);
  // ii_cnt==1 is fine for a grant: the loaded entry becomes visible exactly when the counter reaches 0
  assign slot_free = (~out_vld_q | hs | kill) & (ii_q <= 4'd1);
  assign grant = found & slot_free;
  assign req_rdy_o = grant ? NUM_REQ'(1) << gnt_idx : '0;
  always_comb begin
    lvl_remap = lvl_q;
    for (int k = 0; k <= SPEC_DEPTH; k++)
      if (lvl_q == SPEC_LEVEL_BIT'(k)) lvl_remap = br_pred_succ_nxt_levels_i[k*SPEC_LEVEL_BIT +: SPEC_LEVEL_BIT];
  end
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_vld_i[i] & ~(fail & (req_spec_level_i[i*SPEC_LEVEL_BIT +: SPEC_LEVEL_BIT] >= br_pred_fail_level_i));
  end
  always_comb begin
    found = 1'b0;
    gnt_idx = rr_q;
    j = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_q) + k) % NUM_REQ;
      if (!found && elig[j]) begin
        found = 1'b1;
        gnt_idx = PTR_BIT'(j);
      end
    end
  end
  always_comb begin
    rr_d = grant ? PTR_BIT'((int'(gnt_idx) + 1) % NUM_REQ) : rr_q;
    out_vld_d = grant | (out_vld_q & ~hs & ~kill);
    info_d = grant ? req_info_i[gnt_idx*INFO_BIT +: INFO_BIT] : info_q;
    lvl_d = grant ? req_spec_level_i[gnt_idx*SPEC_LEVEL_BIT +: SPEC_LEVEL_BIT] : out_spec_level_o;
    ii_d = hs ? II_RELOAD : (ii_q != 4'd0 ? ii_q - 4'd1 : 4'd0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
      out_vld_q <= 1'b0;
      info_q <= '0;
      lvl_q <= '0;
      ii_q <= '0;
    end else begin
      rr_q <= rr_d;
      out_vld_q <= out_vld_d;
      info_q <= info_d;
      lvl_q <= lvl_d;
      ii_q <= ii_d;
    end
  end
`ifdef ISSUE_ARB_PERF_EN
  logic [NUM_REQ*16-1:0] gcnt_q, gcnt_d;
  logic [15:0] scnt_q, scnt_d;
  always_comb begin
    gcnt_d = gcnt_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_rdy_o[i] && gcnt_q[i*16 +: 16] != 16'hffff) gcnt_d[i*16 +: 16] = gcnt_q[i*16 +: 16] + 16'd1;
    scnt_d = (|req_vld_i && !grant && scnt_q != 16'hffff) ? scnt_q + 16'd1 : scnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
      scnt_q <= scnt_d;
    end
  end
  assign perf_grant_cnt_o = gcnt_q;
  assign perf_stall_cnt_o = scnt_q;
`endif
endmodule

// File: tb/tb_fu_issue_arbiter.sv
// tb_fu_issue_arbiter: directed and random checks of two fu_issue_arbiter instances (FU_II=1 and FU_II=3).
module tb_fu_issue_arbiter;
  localparam int N = 4, SLB = 3, SD = 4, INFO = 8 + 3 * 3 + 4;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [N-1:0] req_vld;
  logic [N*INFO-1:0] req_info;
  logic [N*SLB-1:0] req_lvl;
  logic out_rdy, br_vld, br_succ;
  logic [SLB-1:0] br_fl;
  logic [SLB*(SD+1)-1:0] br_tab;
  logic [N-1:0] rdy [2];
  logic ovld [2], brrdy [2], idle [2];
  logic [INFO-1:0] oinfo [2];
  logic [SLB-1:0] olvl [2];
`ifdef ISSUE_ARB_PERF_EN
  logic [N*16-1:0] pg [2];
  logic [15:0] ps [2];
`endif
  for (genvar g = 0; g < 2; g++) begin : g_dut
    fu_issue_arbiter #(.FU_II(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_vld_i(req_vld), .req_rdy_o(rdy[g]), .req_info_i(req_info),
      .req_spec_level_i(req_lvl), .out_vld_o(ovld[g]), .out_rdy_i(out_rdy), .out_info_o(oinfo[g]),
      .out_spec_level_o(olvl[g]), .br_pred_vld_i(br_vld), .br_pred_rdy_o(brrdy[g]), .br_pred_succ_i(br_succ),
      .br_pred_fail_level_i(br_fl), .br_pred_succ_nxt_levels_i(br_tab),
`ifdef ISSUE_ARB_PERF_EN
      .perf_grant_cnt_o(pg[g]), .perf_stall_cnt_o(ps[g]),
`endif
      .idle_o(idle[g]));
  end
  int checks = 0, failures = 0;
  int ii_of [2] = '{1, 3};
  int m_rr [2], m_lvl [2], m_ii [2], m_sc [2], e_gnt [2];
  int m_gc [2][N];
  bit m_v [2], e_hs [2], e_kill [2];
  logic [INFO-1:0] m_info [2];
  logic [INFO-1:0] saved;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int lvl(input int i);
    return int'(req_lvl[i*SLB +: SLB]);
  endfunction
  function automatic int remap(input int l);
    return l <= SD ? int'(br_tab[l*SLB +: SLB]) : l;
  endfunction
  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      m_rr[d] = 0; m_v[d] = 0; m_lvl[d] = 0; m_ii[d] = 0; m_info[d] = '0; m_sc[d] = 0;
      for (int i = 0; i < N; i++) m_gc[d][i] = 0;
    end
  endtask
  // Evaluate the reference model for the current inputs and compare the combinational view.
  task automatic settle();
    bit fail, succ, vld, free;
    #4;
    fail = br_vld && !br_succ;
    succ = br_vld && br_succ;
    for (int d = 0; d < 2; d++) begin
      e_kill[d] = fail && m_v[d] && m_lvl[d] >= int'(br_fl);
      vld = m_v[d] && !e_kill[d] && m_ii[d] == 0;
      e_hs[d] = vld && out_rdy;
      free = (!m_v[d] || e_hs[d] || e_kill[d]) && m_ii[d] <= 1;
      e_gnt[d] = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr[d] + k) % N;
        if (e_gnt[d] < 0 && req_vld[i] && !(fail && lvl(i) >= int'(br_fl))) e_gnt[d] = i;
      end
      if (!free) e_gnt[d] = -1;
      chk($sformatf("req_rdy[%0d]", d), rdy[d], e_gnt[d] >= 0 ? 64'(1) << e_gnt[d] : 64'(0));
      chk($sformatf("out_vld[%0d]", d), ovld[d], vld);
      chk($sformatf("idle[%0d]", d), idle[d], !m_v[d] && m_ii[d] == 0);
      chk($sformatf("br_rdy[%0d]", d), brrdy[d], 1);
      if (m_v[d]) begin
        chk($sformatf("out_info[%0d]", d), oinfo[d], m_info[d]);
        chk($sformatf("out_lvl[%0d]", d), olvl[d], succ ? remap(m_lvl[d]) : m_lvl[d]);
      end
    end
  endtask
  task automatic edge_step();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (e_gnt[d] >= 0) begin
        m_v[d] = 1;
        m_info[d] = req_info[e_gnt[d]*INFO +: INFO];
        m_lvl[d] = lvl(e_gnt[d]);
        m_rr[d] = (e_gnt[d] + 1) % N;
        if (m_gc[d][e_gnt[d]] < 65535) m_gc[d][e_gnt[d]]++;
      end else if (e_hs[d] || e_kill[d]) m_v[d] = 0;
      else if (br_vld && br_succ && m_v[d]) m_lvl[d] = remap(m_lvl[d]);
      if (req_vld != 0 && e_gnt[d] < 0 && m_sc[d] < 65535) m_sc[d]++;
      m_ii[d] = e_hs[d] ? ii_of[d] - 1 : (m_ii[d] > 0 ? m_ii[d] - 1 : 0);
    end
    #1;
  endtask
  task automatic rnd_info();
    for (int i = 0; i < N; i++) req_info[i*INFO +: INFO] = INFO'($urandom);
  endtask
  task automatic set_lvl(input int i, input int l);
    req_lvl[i*SLB +: SLB] = SLB'(l);
  endtask
  initial begin
    mreset();
    req_vld = '0; out_rdy = 0; br_vld = 0; br_succ = 0; br_fl = '0; req_lvl = '0;
    for (int k = 0; k <= SD; k++) br_tab[k*SLB +: SLB] = SLB'(k);
    rnd_info();
    settle();
    chk("rst_idle", idle[0], 1);
    chk("rst_rdy", rdy[0], 0);
    rst_n = 1;
    edge_step();
    // all stations ready: rotating grants on FU_II=1, handshake every third cycle on FU_II=3
    req_vld = 4'b1111; out_rdy = 1;
    for (int c = 0; c < 8; c++) begin
      rnd_info();
      settle();
      chk("t1_gnt", rdy[0], 64'(1) << (c % 4));
      chk("t1_vld", ovld[0], c > 0);
      if (c > 0) begin
        chk("t6_hs", ovld[1] & out_rdy, c % 3 == 1);
        chk("t6_idle", idle[1], 0);
      end
      edge_step();
    end
    req_vld = 4'b0100; rnd_info(); settle(); chk("t2_single", rdy[0], 4'b0100); edge_step();
    req_vld = 4'b0101; rnd_info(); settle(); chk("t2_wrap", rdy[0], 4'b0001); edge_step();
    out_rdy = 0; req_vld = 4'b1111;
    settle(); saved = oinfo[0]; chk("t3_hold_rdy", rdy[0], 0); edge_step();
    for (int c = 0; c < 2; c++) begin
      rnd_info(); settle();
      chk("t3_hold_rdy", rdy[0], 0);
      chk("t3_hold_info", oinfo[0], saved);
      edge_step();
    end
    out_rdy = 1; settle(); chk("t3_hs", ovld[0], 1); chk("t3_regrant", rdy[0], 4'b0010); edge_step();
    req_vld = 4'b0001; set_lvl(0, 2); rnd_info(); settle(); chk("t4_load", rdy[0], 4'b0001); edge_step();
    out_rdy = 0; req_vld = 4'b0110; set_lvl(1, 3); set_lvl(2, 1);
    br_vld = 1; br_succ = 0; br_fl = 3'd2;
    settle(); chk("t4_kill", ovld[0], 0); chk("t4_mask", rdy[0], 4'b0100); edge_step();
    br_vld = 0; req_vld = '0;
    settle(); chk("t4_new_vld", ovld[0], 1); chk("t4_new_lvl", olvl[0], 1); edge_step();
    br_vld = 1; br_fl = 3'd0; settle(); chk("t4_kill2", ovld[0], 0); edge_step();
    br_vld = 0; settle(); chk("t4_empty", idle[0], 1); edge_step();
    out_rdy = 1; req_vld = 4'b0001; set_lvl(0, 3); settle(); chk("t5_load", rdy[0], 4'b0001); edge_step();
    out_rdy = 0; req_vld = '0; br_vld = 1; br_succ = 1;
    for (int k = 0; k <= SD; k++) br_tab[k*SLB +: SLB] = SLB'(k > 0 ? k - 1 : 0);
    settle(); chk("t5_remap_now", olvl[0], 2); edge_step();
    br_vld = 0; settle(); chk("t5_remap_kept", olvl[0], 2); edge_step();
    for (int c = 0; c < 400; c++) begin
      req_vld = N'($urandom); out_rdy = $urandom_range(0, 3) != 0;
      br_vld = $urandom_range(0, 3) == 0; br_succ = 1'($urandom); br_fl = SLB'($urandom_range(0, SD));
      for (int k = 0; k <= SD; k++) br_tab[k*SLB +: SLB] = SLB'($urandom_range(0, SD));
      for (int i = 0; i < N; i++) set_lvl(i, $urandom_range(0, SD));
      rnd_info();
      settle();
      edge_step();
    end
    req_vld = 4'b1111; out_rdy = 0; br_vld = 0; settle(); edge_step();
    #2 rst_n = 0; req_vld = '0;
    #1 mreset();
    chk("arst_vld", ovld[0], 0);
    chk("arst_idle0", idle[0], 1);
    chk("arst_idle1", idle[1], 1);
    chk("arst_rdy", rdy[0], 0);
    rst_n = 1;
    edge_step();
    for (int c = 0; c < 100; c++) begin
      req_vld = N'($urandom); out_rdy = 1'($urandom); br_vld = $urandom_range(0, 4) == 0;
      br_succ = 1'($urandom); br_fl = SLB'($urandom_range(0, SD));
      for (int i = 0; i < N; i++) set_lvl(i, $urandom_range(0, SD));
      rnd_info();
      settle();
      edge_step();
    end
`ifdef ISSUE_ARB_PERF_EN
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) chk($sformatf("perf_grant[%0d][%0d]", d, i), pg[d][i*16 +: 16], m_gc[d][i]);
      chk($sformatf("perf_stall[%0d]", d), ps[d], m_sc[d]);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
